// File: rtl/axi_ddr_sched_pkg.sv
// Shared types and widths for the DDR address-channel scheduler.
package axi_ddr_sched_pkg;

   localparam int OUTST_W = 4;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_RD = 2'd1,
      GNT_WR = 2'd2
   } sched_state_e;

   typedef enum logic {
      DIR_RD = 1'b0,
      DIR_WR = 1'b1
   } dir_e;

endpackage

// File: rtl/axi_ddr_outst_ctr.sv
// Up/down counter of outstanding transactions for one direction.
// It saturates at MAX_OUTST and holds at zero, where a lone decrement
// is reported as an underflow.
module axi_ddr_outst_ctr
   import axi_ddr_sched_pkg::*;
#(
   parameter int MAX_OUTST = 8
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               inc,
   input  logic               dec,
   output logic [OUTST_W-1:0] cnt,
   output logic [OUTST_W-1:0] cnt_next,
   output logic               full,
   output logic               empty,
   output logic               underflow
);

   localparam logic [OUTST_W-1:0] MAX_VAL = OUTST_W'(MAX_OUTST);

   // Next count: a simultaneous +1/-1 cancels; a lone -1 at zero is an underflow.
   always_comb begin
      cnt_next  = cnt;
      underflow = 1'b0;
      if (inc && !dec) begin
         if (cnt < MAX_VAL)
            cnt_next = cnt + OUTST_W'(1);
      end else if (dec && !inc) begin
         if (cnt == '0)
            underflow = 1'b1;
         else
            cnt_next = cnt - OUTST_W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk) begin
      if (rst)
         cnt <= '0;
      else
         cnt <= cnt_next;
   end

   assign full  = (cnt >= MAX_VAL);
   assign empty = (cnt == '0);

endmodule

// File: rtl/axi_ddr_txn_scheduler.sv
// Round-robin AR/AW address gate in front of the external DDR AXI port.
// It caps outstanding reads and writes, supports drain/quiesce, and
// runs a watchdog on responses. Payloads bypass this block.
module axi_ddr_txn_scheduler
   import axi_ddr_sched_pkg::*;
#(
   parameter int MAX_OUTST = 8,
   parameter int TIMEOUT_W = 16
)
(
   input  logic               clk,
   input  logic               rst,
   input  logic               s_ar_valid,
   output logic               s_ar_ready,
   input  logic               s_aw_valid,
   output logic               s_aw_ready,
   output logic               m_ar_valid,
   input  logic               m_ar_ready,
   output logic               m_aw_valid,
   input  logic               m_aw_ready,
   input  logic               r_hs_last,
   input  logic               b_hs,
   input  logic               drain_req_i,
   output logic               drain_ack_o,
   input  logic               err_clr_i,
   output logic               timeout_o,
   output logic               proto_err_o,
   output logic [OUTST_W-1:0] rd_outst_o,
   output logic [OUTST_W-1:0] wr_outst_o
);

   localparam logic [OUTST_W-1:0]   MAX_VAL = OUTST_W'(MAX_OUTST);
   localparam logic [TIMEOUT_W-1:0] WD_MAX  = '1;

   sched_state_e         state, state_next;
   dir_e                 last_gnt, last_gnt_next;
   logic [OUTST_W-1:0]   rd_cnt, rd_cnt_next, wr_cnt, wr_cnt_next;
   logic                 rd_full, rd_empty, rd_uf;
   logic                 wr_full, wr_empty, wr_uf;
   logic                 ar_hs, aw_hs;
   logic                 rd_elig_now, wr_elig_now, rd_elig_post, wr_elig_post;
   logic [TIMEOUT_W-1:0] wd_cnt;
   logic                 wd_clear, wd_fire;

   function automatic sched_state_e arbitrate(input logic rd_ok, input logic wr_ok, input dir_e last);
      if (rd_ok && wr_ok)
         return (last == DIR_RD) ? GNT_WR : GNT_RD;
      else if (rd_ok)
         return GNT_RD;
      else if (wr_ok)
         return GNT_WR;
      else
         return IDLE;
   endfunction

   axi_ddr_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_rd_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc       (ar_hs),
      .dec       (r_hs_last),
      .cnt       (rd_cnt),
      .cnt_next  (rd_cnt_next),
      .full      (rd_full),
      .empty     (rd_empty),
      .underflow (rd_uf)
   );

   axi_ddr_outst_ctr #(.MAX_OUTST(MAX_OUTST)) u_wr_ctr (
      .clk       (clk),
      .rst       (rst),
      .inc       (aw_hs),
      .dec       (b_hs),
      .cnt       (wr_cnt),
      .cnt_next  (wr_cnt_next),
      .full      (wr_full),
      .empty     (wr_empty),
      .underflow (wr_uf)
   );

   // The granted channel passes straight through; the other is held off.
   always_comb begin
      m_ar_valid = (state == GNT_RD) & s_ar_valid;
      s_ar_ready = (state == GNT_RD) & m_ar_ready;
      m_aw_valid = (state == GNT_WR) & s_aw_valid;
      s_aw_ready = (state == GNT_WR) & m_aw_ready;
   end

   assign ar_hs = m_ar_valid & m_ar_ready;
   assign aw_hs = m_aw_valid & m_aw_ready;

   // "post" eligibility looks at the counts as they will be after this cycle,
   // so a back-to-back grant never pushes a direction past its cap.
   assign rd_elig_now  = s_ar_valid & ~rd_full & ~drain_req_i;
   assign wr_elig_now  = s_aw_valid & ~wr_full & ~drain_req_i;
   assign rd_elig_post = s_ar_valid & (rd_cnt_next < MAX_VAL) & ~drain_req_i;
   assign wr_elig_post = s_aw_valid & (wr_cnt_next < MAX_VAL) & ~drain_req_i;

   // Grant sequencing. A grant with no valid presented has nothing to keep
   // stable, so it is re-arbitrated like IDLE rather than parked forever.
   always_comb begin
      state_next    = state;
      last_gnt_next = last_gnt;
      case (state)
         GNT_RD: begin
            if (ar_hs) begin
               last_gnt_next = DIR_RD;
               state_next    = arbitrate(rd_elig_post, wr_elig_post, DIR_RD);
            end else if (!s_ar_valid) begin
               state_next = arbitrate(rd_elig_now, wr_elig_now, last_gnt);
            end
         end
         GNT_WR: begin
            if (aw_hs) begin
               last_gnt_next = DIR_WR;
               state_next    = arbitrate(rd_elig_post, wr_elig_post, DIR_WR);
            end else if (!s_aw_valid) begin
               state_next = arbitrate(rd_elig_now, wr_elig_now, last_gnt);
            end
         end
         default: begin
            state_next = arbitrate(rd_elig_now, wr_elig_now, last_gnt);
         end
      endcase
   end

   // State and last-grant registers; after reset reads win the first tie.
   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         last_gnt <= DIR_WR;
      end else begin
         state    <= state_next;
         last_gnt <= last_gnt_next;
      end
   end

   // Drain acknowledge: idle with nothing outstanding while drain is requested.
   always_ff @(posedge clk) begin
      if (rst)
         drain_ack_o <= 1'b0;
      else
         drain_ack_o <= drain_req_i & (state == IDLE) & rd_empty & wr_empty;
   end

   assign wd_clear = r_hs_last | b_hs | (rd_empty & wr_empty);
   assign wd_fire  = ~wd_clear & (wd_cnt == WD_MAX - TIMEOUT_W'(1));

   // Response watchdog: counts cycles without a response while work is pending,
   // and sticks at all-ones instead of wrapping.
   always_ff @(posedge clk) begin
      if (rst)
         wd_cnt <= '0;
      else if (wd_clear)
         wd_cnt <= '0;
      else if (wd_cnt != WD_MAX)
         wd_cnt <= wd_cnt + TIMEOUT_W'(1);
   end

   // Sticky error flags; a new event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_o   <= 1'b0;
         proto_err_o <= 1'b0;
      end else begin
         timeout_o   <= wd_fire | (timeout_o & ~err_clr_i);
         proto_err_o <= rd_uf | wr_uf | (proto_err_o & ~err_clr_i);
      end
   end

   assign rd_outst_o = rd_cnt;
   assign wr_outst_o = wr_cnt;

endmodule

// File: tb/tb_axi_ddr_txn_scheduler.sv
// Self-checking bench for axi_ddr_txn_scheduler: directed vector table,
// hand-written corner sequences and random traffic against a reference model.
module tb_axi_ddr_txn_scheduler;

   localparam int MAXO  = 8;
   localparam int TW    = 4;
   localparam int WDMAX = (1 << TW) - 1;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       s_ar_valid = 1'b0, s_ar_ready;
   logic       s_aw_valid = 1'b0, s_aw_ready;
   logic       m_ar_valid, m_ar_ready = 1'b0;
   logic       m_aw_valid, m_aw_ready = 1'b0;
   logic       r_hs_last = 1'b0, b_hs = 1'b0;
   logic       drain_req_i = 1'b0, drain_ack_o;
   logic       err_clr_i = 1'b0, timeout_o, proto_err_o;
   logic [3:0] rd_outst_o, wr_outst_o;

   int total = 0;
   int bad   = 0;

   // Reference model: grant is 0 none / 1 read / 2 write, last is 1 read / 2 write.
   int mGrant = 0;
   int mLast  = 2;
   int mRd    = 0;
   int mWr    = 0;
   int mAge   = 0;
   bit mTo    = 0;
   bit mPe    = 0;
   bit mAck   = 0;

   typedef struct {
      logic sAr, sAw, mArRdy, mAwRdy, rLast, bHs, drain, clr;
   } stim_t;

   typedef struct {
      stim_t in;
      logic  expMArValid;
      logic  expSArReady;
      int    expRd;
      int    expWr;
      logic  expPe;
   } vec_t;

   always #5 clk = ~clk;

   axi_ddr_txn_scheduler #(.MAX_OUTST(MAXO), .TIMEOUT_W(TW)) dut (
      .clk         (clk),
      .rst         (rst),
      .s_ar_valid  (s_ar_valid),
      .s_ar_ready  (s_ar_ready),
      .s_aw_valid  (s_aw_valid),
      .s_aw_ready  (s_aw_ready),
      .m_ar_valid  (m_ar_valid),
      .m_ar_ready  (m_ar_ready),
      .m_aw_valid  (m_aw_valid),
      .m_aw_ready  (m_aw_ready),
      .r_hs_last   (r_hs_last),
      .b_hs        (b_hs),
      .drain_req_i (drain_req_i),
      .drain_ack_o (drain_ack_o),
      .err_clr_i   (err_clr_i),
      .timeout_o   (timeout_o),
      .proto_err_o (proto_err_o),
      .rd_outst_o  (rd_outst_o),
      .wr_outst_o  (wr_outst_o)
   );

   function automatic stim_t mk(input logic a, b, c, d, e, f, g, h);
      stim_t s;
      s.sAr = a; s.sAw = b; s.mArRdy = c; s.mAwRdy = d;
      s.rLast = e; s.bHs = f; s.drain = g; s.clr = h;
      return s;
   endfunction

   function automatic vec_t mkVec(input stim_t s, input logic mav, input logic sar,
                                  input int rd, input int wr, input logic pe);
      vec_t v;
      v.in = s; v.expMArValid = mav; v.expSArReady = sar;
      v.expRd = rd; v.expWr = wr; v.expPe = pe;
      return v;
   endfunction

   // Round-robin pick: a tie goes to the direction not granted last.
   function automatic int pick(input bit rdOk, input bit wrOk, input int last);
      if (rdOk && wrOk) return (last == 1) ? 2 : 1;
      if (rdOk) return 1;
      if (wrOk) return 2;
      return 0;
   endfunction

   task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s got=%0d want=%0d", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input stim_t s);
      s_ar_valid  = s.sAr;
      s_aw_valid  = s.sAw;
      m_ar_ready  = s.mArRdy;
      m_aw_ready  = s.mAwRdy;
      r_hs_last   = s.rLast;
      b_hs        = s.bHs;
      drain_req_i = s.drain;
      err_clr_i   = s.clr;
   endtask

   // Advance the model by one clock edge using the inputs currently applied.
   task automatic modelAdvance();
      int  rdHs, wrHs, rdN, wrN;
      bit  toEv, peEv;
      if (rst) begin
         mGrant = 0; mLast = 2; mRd = 0; mWr = 0; mAge = 0;
         mTo = 0; mPe = 0; mAck = 0;
         return;
      end
      rdHs = (mGrant == 1 && s_ar_valid && m_ar_ready) ? 1 : 0;
      wrHs = (mGrant == 2 && s_aw_valid && m_aw_ready) ? 1 : 0;
      peEv = 0;
      toEv = 0;
      rdN = mRd + rdHs - (r_hs_last ? 1 : 0);
      wrN = mWr + wrHs - (b_hs ? 1 : 0);
      if (rdN < 0) begin rdN = 0; peEv = 1; end
      if (wrN < 0) begin wrN = 0; peEv = 1; end
      if (rdN > MAXO) rdN = MAXO;
      if (wrN > MAXO) wrN = MAXO;
      if (r_hs_last || b_hs || (mRd == 0 && mWr == 0))
         mAge = 0;
      else if (mAge < WDMAX) begin
         mAge++;
         if (mAge == WDMAX) toEv = 1;
      end
      mAck = drain_req_i && mGrant == 0 && mRd == 0 && mWr == 0;
      if (mGrant == 0 || (mGrant == 1 && !s_ar_valid) || (mGrant == 2 && !s_aw_valid))
         mGrant = pick(s_ar_valid && mRd < MAXO && !drain_req_i,
                       s_aw_valid && mWr < MAXO && !drain_req_i, mLast);
      else if (rdHs == 1 || wrHs == 1) begin
         mLast  = (rdHs == 1) ? 1 : 2;
         mGrant = pick(s_ar_valid && rdN < MAXO && !drain_req_i,
                       s_aw_valid && wrN < MAXO && !drain_req_i, mLast);
      end
      mTo = toEv || (mTo && !err_clr_i);
      mPe = peEv || (mPe && !err_clr_i);
      mRd = rdN;
      mWr = wrN;
   endtask

   // Called at the negedge: compare every output with the model, then step.
   task automatic checkOutput(input string tag);
      cmp({tag, ".m_ar_valid"}, m_ar_valid, (mGrant == 1) && s_ar_valid);
      cmp({tag, ".s_ar_ready"}, s_ar_ready, (mGrant == 1) && m_ar_ready);
      cmp({tag, ".m_aw_valid"}, m_aw_valid, (mGrant == 2) && s_aw_valid);
      cmp({tag, ".s_aw_ready"}, s_aw_ready, (mGrant == 2) && m_aw_ready);
      cmp({tag, ".drain_ack"}, drain_ack_o, mAck);
      cmp({tag, ".timeout"}, timeout_o, mTo);
      cmp({tag, ".proto_err"}, proto_err_o, mPe);
      cmp({tag, ".rd_outst"}, rd_outst_o, mRd);
      cmp({tag, ".wr_outst"}, wr_outst_o, mWr);
      modelAdvance();
      @(posedge clk);
      #1;
   endtask

   task automatic stepCycle(input string tag);
      @(negedge clk);
      checkOutput(tag);
   endtask

   task automatic doReset();
      rst = 1'b1;
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 0));
      stepCycle("rst0");
      @(negedge clk);
      cmp("reset.m_ar_valid", m_ar_valid, 0);
      cmp("reset.m_aw_valid", m_aw_valid, 0);
      cmp("reset.drain_ack", drain_ack_o, 0);
      cmp("reset.flags", {timeout_o, proto_err_o}, 0);
      cmp("reset.counts", {rd_outst_o, wr_outst_o}, 0);
      checkOutput("rst1");
      rst = 1'b0;
   endtask

   initial begin
      #1ms;
      $display("[TB] FAIL global_timeout got=running want=finished");
      $fatal(1, "[TB] simulation time limit reached");
   end

   initial begin
      vec_t  vecs[9];
      stim_t z;
      int    rdLeft, wrLeft, hs, waited;
      bit    granted, seen;
      int    order[$];

      z = mk(0, 0, 0, 0, 0, 0, 0, 0);
      vecs[0] = mkVec(mk(1, 0, 1, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
      vecs[1] = mkVec(mk(1, 0, 1, 0, 0, 0, 0, 0), 1, 1, 0, 0, 0);
      vecs[2] = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 1, 0, 0);
      vecs[3] = mkVec(mk(0, 0, 0, 0, 1, 0, 0, 0), 0, 0, 1, 0, 0);
      vecs[4] = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);
      vecs[5] = mkVec(mk(0, 0, 0, 0, 0, 1, 0, 0), 0, 0, 0, 0, 0);
      vecs[6] = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 1);
      vecs[7] = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 1), 0, 0, 0, 0, 1);
      vecs[8] = mkVec(mk(0, 0, 0, 0, 0, 0, 0, 0), 0, 0, 0, 0, 0);

      $display("[TB] start");
      #1;
      doReset();

      // Single read, then an underflowing write response and error clear.
      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].in);
         @(negedge clk);
         cmp($sformatf("vec%0d.m_ar_valid", i), m_ar_valid, vecs[i].expMArValid);
         cmp($sformatf("vec%0d.s_ar_ready", i), s_ar_ready, vecs[i].expSArReady);
         cmp($sformatf("vec%0d.rd_outst", i), rd_outst_o, vecs[i].expRd);
         cmp($sformatf("vec%0d.wr_outst", i), wr_outst_o, vecs[i].expWr);
         cmp($sformatf("vec%0d.proto_err", i), proto_err_o, vecs[i].expPe);
         checkOutput($sformatf("vec%0d", i));
      end

      // Three writes, then a fourth handshake coinciding with a b_hs.
      applyStimulus(mk(0, 1, 0, 1, 0, 0, 0, 0));
      repeat (4) stepCycle("aw3");
      applyStimulus(mk(0, 1, 0, 1, 0, 1, 0, 0));
      stepCycle("aw_b_same");
      applyStimulus(z);
      @(negedge clk);
      cmp("same_cycle.wr_outst", wr_outst_o, 3);
      checkOutput("aw_settle");
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0));
      repeat (3) stepCycle("b_drain");
      applyStimulus(z);
      stepCycle("b_idle");

      // Both channels busy: grants must alternate starting with a read.
      doReset();
      rdLeft = 4;
      wrLeft = 4;
      for (int c = 0; c < 20 && (rdLeft > 0 || wrLeft > 0); c++) begin
         applyStimulus(mk(rdLeft > 0, wrLeft > 0, 1, 1, 0, 0, 0, 0));
         @(negedge clk);
         if (m_ar_valid && m_ar_ready) begin order.push_back(1); rdLeft--; end
         if (m_aw_valid && m_aw_ready) begin order.push_back(2); wrLeft--; end
         checkOutput("alt");
      end
      cmp("alt.count", order.size(), 8);
      for (int i = 0; i < order.size() && i < 8; i++)
         cmp($sformatf("alt.order%0d", i), order[i], (i % 2 == 0) ? 1 : 2);
      applyStimulus(mk(0, 0, 0, 0, 1, 1, 0, 0));
      repeat (4) stepCycle("alt_resp");
      applyStimulus(z);
      stepCycle("alt_idle");

      // Fill reads to the cap; the ninth waits for a response.
      doReset();
      hs = 0;
      for (int c = 0; c < 30 && hs < 8; c++) begin
         applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0));
         @(negedge clk);
         if (m_ar_valid && m_ar_ready) hs++;
         checkOutput("rd8");
      end
      cmp("cap.handshakes", hs, 8);
      repeat (3) begin
         applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0));
         @(negedge clk);
         cmp("cap.blocked_ready", s_ar_ready, 0);
         cmp("cap.rd_outst", rd_outst_o, 8);
         checkOutput("rd9_wait");
      end
      applyStimulus(mk(1, 0, 1, 0, 1, 0, 0, 0));
      stepCycle("rd9_resp");
      granted = 0;
      for (int c = 0; c < 5 && !granted; c++) begin
         applyStimulus(mk(1, 0, 1, 0, 0, 0, 0, 0));
         @(negedge clk);
         if (m_ar_valid && s_ar_ready) granted = 1;
         checkOutput("rd9_grant");
      end
      cmp("cap.ninth_granted", granted, 1);
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 0, 0));
      repeat (8) stepCycle("rd_resp");
      applyStimulus(z);
      @(negedge clk);
      cmp("cap.drained", rd_outst_o, 0);
      checkOutput("rd_idle");

      // Drain raised while a read grant waits on a stalled downstream.
      doReset();
      applyStimulus(mk(1, 0, 0, 0, 0, 0, 0, 0));
      stepCycle("dr_grant");
      for (int k = 0; k < 3; k++) begin
         applyStimulus(mk(1, 0, 0, 0, 0, 0, 1, 0));
         @(negedge clk);
         cmp("drain.hold_valid", m_ar_valid, 1);
         checkOutput("dr_hold");
      end
      applyStimulus(mk(1, 0, 1, 0, 0, 0, 1, 0));
      @(negedge clk);
      cmp("drain.handshake", m_ar_valid && s_ar_ready, 1);
      checkOutput("dr_hs");
      applyStimulus(mk(0, 0, 0, 0, 1, 0, 1, 0));
      @(negedge clk);
      cmp("drain.idle_valid", m_ar_valid, 0);
      cmp("drain.ack_pending", drain_ack_o, 0);
      cmp("drain.rd_outst", rd_outst_o, 1);
      checkOutput("dr_resp");
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 1, 0));
      @(negedge clk);
      cmp("drain.ack_not_yet", drain_ack_o, 0);
      checkOutput("dr_w0");
      @(negedge clk);
      cmp("drain.ack", drain_ack_o, 1);
      checkOutput("dr_w1");
      applyStimulus(z);
      @(negedge clk);
      cmp("drain.ack_lag", drain_ack_o, 1);
      checkOutput("dr_fall");
      @(negedge clk);
      cmp("drain.ack_dropped", drain_ack_o, 0);
      checkOutput("dr_done");

      // Watchdog: one write with no response.
      doReset();
      applyStimulus(mk(0, 1, 0, 1, 0, 0, 0, 0));
      stepCycle("wd_grant");
      stepCycle("wd_hs");
      applyStimulus(z);
      waited = 0;
      seen = 0;
      for (int c = 0; c < 40 && !seen; c++) begin
         @(negedge clk);
         if (timeout_o) seen = 1;
         else if (wr_outst_o != 0) waited++;
         checkOutput("wd_wait");
      end
      cmp("wd.fired", seen, 1);
      cmp("wd.cycles", waited, WDMAX);
      applyStimulus(mk(0, 0, 0, 0, 0, 0, 0, 1));
      @(negedge clk);
      cmp("wd.still_set", timeout_o, 1);
      checkOutput("wd_clr");
      applyStimulus(z);
      @(negedge clk);
      cmp("wd.cleared", timeout_o, 0);
      checkOutput("wd_after");
      applyStimulus(mk(0, 0, 0, 0, 0, 1, 0, 0));
      stepCycle("wd_b");
      applyStimulus(z);
      stepCycle("wd_idle");

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         stim_t s;
         s.sAr    = ($urandom_range(0, 9) < 6);
         s.sAw    = ($urandom_range(0, 9) < 6);
         s.mArRdy = ($urandom_range(0, 9) < 7);
         s.mAwRdy = ($urandom_range(0, 9) < 7);
         s.rLast  = ($urandom_range(0, 9) < 2);
         s.bHs    = ($urandom_range(0, 9) < 2);
         s.drain  = ($urandom_range(0, 49) == 0) ? !drain_req_i : drain_req_i;
         s.clr    = ($urandom_range(0, 39) == 0);
         applyStimulus(s);
         stepCycle("rand");
      end
      applyStimulus(z);
      repeat (2) stepCycle("end");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
